// File: rtl/dac_seq_pkg.sv
// Shared types and default sizing for the dac_seq sample player.
package dac_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_DIV_W      = 16;

endpackage

// File: rtl/dac_seq_fifo.sv
// Synchronous sample FIFO with flush, full/empty flags and occupancy level.
module dac_seq_fifo
    import dac_seq_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign full  = (r_level == LW'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;
    assign rdata = r_mem[r_rd_ptr];

    // Flush wins over both push and pop in the same cycle.
    assign w_push = push && !full  && !flush;
    assign w_pop  = pop  && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/dac_seq.sv
// Paced DAC sample player: FIFO-fed, divider-timed updates with sticky underrun.
// Optional ramp test pattern is built only when DAC_SEQ_RAMP_EN is defined.
module dac_seq
    import dac_seq_pkg::*;
#(
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int DIV_W      = DEF_DIV_W,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [7:0]       dac_d,
    output logic             upd,
    output logic             underrun,
    input  logic             clr_underrun,
    output logic [LW-1:0]    level,
    input  logic             test_mode
);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [7:0]       r_dac;
    logic             r_upd;
    logic             r_underrun;

    logic             w_tick;
    logic             w_ramp;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_head;

`ifdef DAC_SEQ_RAMP_EN
    assign w_ramp = test_mode;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_ramp = 1'b0;
`endif

    // A tick needs en still high, so dropping en abandons the pending one.
    assign w_tick = (r_state == RUN) && en && (r_cnt == '0);
    assign w_push = in_valid && in_ready;
    assign w_pop  = w_tick && !flush && !w_empty && !w_ramp;

    assign in_ready = !w_full;
    assign dac_d    = r_dac;
    assign upd      = r_upd;
    assign underrun = r_underrun;

    dac_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush),
        .wdata (in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dac      <= 8'h00;
            r_upd      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_upd <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= RUN;
                        r_cnt   <= div;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_cnt <= div;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // Clear first so that a same-cycle underrun below overrides it.
            if (clr_underrun) begin
                r_underrun <= 1'b0;
            end

            if (w_tick && !flush) begin
`ifdef DAC_SEQ_RAMP_EN
                if (test_mode) begin
                    r_dac <= r_dac + 8'd1;
                    r_upd <= 1'b1;
                end else
`endif
                if (!w_empty) begin
                    r_dac <= w_head;
                    r_upd <= 1'b1;
                end else begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_seq.sv
// Directed self-checking bench for dac_seq (default depth 4, 16-bit divider).
// Ramp expectations apply when DAC_SEQ_RAMP_EN is defined.
module tb_dac_seq;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [15:0] div;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  dac_d;
    logic        upd;
    logic        underrun;
    logic        clr_underrun;
    logic [2:0]  level;
    logic        test_mode;

    int n_checks;
    int n_errors;

    dac_seq #(
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .div          (div),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .dac_d        (dac_d),
        .upd          (upd),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .level        (level),
        .test_mode    (test_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rstn         = 1'b0;
        en           = 1'b0;
        div          = 16'd0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        clr_underrun = 1'b0;
        test_mode    = 1'b0;

        // Reset state
        step(2);
        chk("rst_dac", dac_d, 8'h00);
        chk("rst_upd", upd, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        rstn = 1'b1;
        step(1);
        $display("txn reset done");

        // div=3, two samples, then an underrun on the third tick
        div = 16'd3;
        in_valid = 1'b1; in_data = 8'h10; step(1);
        in_data = 8'h20; step(1);
        in_valid = 1'b0;
        chk("t1_level2", level, 3'd2);
        en = 1'b1;
        step(1);
        step(3);
        chk("t1_no_upd_c3", upd, 1'b0);
        chk("t1_dac_c3", dac_d, 8'h00);
        step(1);
        chk("t1_upd_c4", upd, 1'b1);
        chk("t1_dac_c4", dac_d, 8'h10);
        chk("t1_level_c4", level, 3'd1);
        step(1);
        chk("t1_upd_pulse", upd, 1'b0);
        step(3);
        chk("t1_upd_c8", upd, 1'b1);
        chk("t1_dac_c8", dac_d, 8'h20);
        chk("t1_ur_c8", underrun, 1'b0);
        step(3);
        chk("t1_ur_c11", underrun, 1'b0);
        step(1);
        chk("t1_ur_c12", underrun, 1'b1);
        chk("t1_upd_c12", upd, 1'b0);
        chk("t1_dac_c12", dac_d, 8'h20);
        en = 1'b0;
        step(1);
        clr_underrun = 1'b1; step(1); clr_underrun = 1'b0;
        chk("t1_ur_clr", underrun, 1'b0);
        $display("txn div3 playback done");

        // Fill to full with en=0, extra push ignored, first tick frees a slot
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hA1 + 8'(i);
            step(1);
        end
        chk("t2_in_ready_full", in_ready, 1'b0);
        chk("t2_level_full", level, 3'd4);
        in_data = 8'hEE; step(1);
        in_valid = 1'b0;
        chk("t2_level_extra", level, 3'd4);
        en = 1'b1;
        step(5);
        chk("t2_dac_tick", dac_d, 8'hA1);
        chk("t2_level_tick", level, 3'd3);
        chk("t2_in_ready_tick", in_ready, 1'b1);
        en = 1'b0;
        step(1);
        $display("txn full fifo done");

        // Flush with concurrent push at level 3
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("t3_level_flush", level, 3'd0);
        chk("t3_dac_flush", dac_d, 8'hA1);
        chk("t3_ur_flush", underrun, 1'b0);
        $display("txn flush done");

        // div=0 full FIFO: four back-to-back updates, then underrun (set beats clear)
        div = 16'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h01 + 8'(i);
            step(1);
        end
        in_valid = 1'b0;
        en = 1'b1;
        step(1);
        chk("t4_upd_c0", upd, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t4_upd_burst", upd, 1'b1);
            chk("t4_dac_burst", dac_d, 8'h01 + 8'(i));
            chk("t4_level_burst", level, 32'(3 - i));
        end
        chk("t4_ur_before", underrun, 1'b0);
        clr_underrun = 1'b1;
        step(1);
        chk("t4_ur_set_wins", underrun, 1'b1);
        chk("t4_upd_empty", upd, 1'b0);
        chk("t4_dac_held", dac_d, 8'h04);
        en = 1'b0;
        step(1);
        clr_underrun = 1'b0;
        chk("t4_ur_cleared", underrun, 1'b0);
        $display("txn div0 burst done");

        // Push into empty FIFO on a tick cycle is not bypassed
        div = 16'd1;
        en = 1'b1;
        step(2);
        in_valid = 1'b1; in_data = 8'h33;
        step(1);
        in_valid = 1'b0;
        chk("t5_ur_nobypass", underrun, 1'b1);
        chk("t5_upd_nobypass", upd, 1'b0);
        chk("t5_level_nobypass", level, 3'd1);
        step(2);
        chk("t5_dac_next", dac_d, 8'h33);
        chk("t5_upd_next", upd, 1'b1);
        // en dropped on the would-be tick: no pop, contents kept
        in_valid = 1'b1; in_data = 8'h44;
        step(1);
        in_valid = 1'b0; en = 1'b0;
        step(1);
        chk("t5_abandon_dac", dac_d, 8'h33);
        chk("t5_abandon_level", level, 3'd1);
        chk("t5_abandon_upd", upd, 1'b0);
        clr_underrun = 1'b1; step(1); clr_underrun = 1'b0;
        chk("t5_ur_clr", underrun, 1'b0);
        $display("txn no-bypass and abandon done");

        // Load 8'hFE, then run with test_mode=1
        in_valid = 1'b1; in_data = 8'hFE; step(1);
        in_valid = 1'b0;
        div = 16'd0; en = 1'b1;
        step(3);
        chk("t6_dac_fe", dac_d, 8'hFE);
        chk("t6_level_fe", level, 3'd0);
        en = 1'b0;
        step(1);
        in_valid = 1'b1; in_data = 8'h99; step(1);
        in_valid = 1'b0;
        div = 16'd1; test_mode = 1'b1; en = 1'b1;
        step(3);
`ifdef DAC_SEQ_RAMP_EN
        chk("t6_ramp_ff", dac_d, 8'hFF);
        chk("t6_ramp_upd", upd, 1'b1);
        chk("t6_ramp_level1", level, 3'd1);
        step(2);
        chk("t6_ramp_wrap", dac_d, 8'h00);
        chk("t6_ramp_level2", level, 3'd1);
        chk("t6_ramp_ur", underrun, 1'b0);
`else
        chk("t6_tm_ignored_dac", dac_d, 8'h99);
        chk("t6_tm_ignored_upd", upd, 1'b1);
        chk("t6_tm_ignored_level", level, 3'd0);
        step(2);
        chk("t6_tm_ignored_ur", underrun, 1'b1);
        chk("t6_tm_ignored_hold", dac_d, 8'h99);
`endif
        en = 1'b0; test_mode = 1'b0;
        step(1);
        clr_underrun = 1'b1; flush = 1'b1; step(1);
        clr_underrun = 1'b0; flush = 1'b0;
        chk("t6_cleanup_ur", underrun, 1'b0);
        chk("t6_cleanup_level", level, 3'd0);
        $display("txn test_mode done");

        // Asynchronous reset in the middle of playback
        in_valid = 1'b1; in_data = 8'h5A; step(1);
        in_data = 8'h5B; step(1);
        in_valid = 1'b0;
        div = 16'd0; en = 1'b1;
        step(2);
        chk("t7_dac_5a", dac_d, 8'h5A);
        chk("t7_level_pre", level, 3'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t7_rst_dac", dac_d, 8'h00);
        chk("t7_rst_level", level, 3'd0);
        chk("t7_rst_in_ready", in_ready, 1'b1);
        chk("t7_rst_upd", upd, 1'b0);
        chk("t7_rst_ur", underrun, 1'b0);
        en = 1'b0;
        step(1);
        rstn = 1'b1;
        step(1);
        chk("t7_after_rst_dac", dac_d, 8'h00);
        $display("txn async reset done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_seq.md
DAC_SEQ -- requirements
Module: dac_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sample FIFO entries; power of two, >= 2.
REQ-002 Parameter DIV_W, default 16, width of the sample-period divider.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  playback enable; 1 = RUN, 0 = IDLE.
REQ-006 div  in  DIV_W  sample period minus 1, in clk cycles; sampled at every reload.
REQ-007 flush  in  1  synchronous FIFO clear.
REQ-008 in_valid  in  1  producer has a sample.
REQ-009 in_data  in  8  sample code.
REQ-010 in_ready  out  1  FIFO can accept.
REQ-011 dac_d  out  8  registered DAC code; bit i drives DAC input di.
REQ-012 upd  out  1  one-cycle pulse, dac_d loaded this cycle.
REQ-013 underrun  out  1  sticky, tick found FIFO empty.
REQ-014 clr_underrun  in  1  clears underrun.
REQ-015 level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 test_mode  in  1  ramp select; port always present.

Function
REQ-017 States IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE when en=0, same edge.
REQ-018 IDLE: divider counter held 0, dac_d holds last value, upd=0, FIFO still accepts pushes.
REQ-019 Entry to RUN loads counter with div; each RUN cycle counter decrements; counter==0 is a tick and reloads div.
REQ-020 First tick div+1 cycles after en sampled high; then period div+1; div=0 gives a tick every cycle.
REQ-021 Tick with FIFO non-empty: pop head into dac_d, upd=1 next cycle-edge output.
REQ-022 Tick with FIFO empty: dac_d held, upd=0, underrun set.
REQ-023 in_ready = !full, combinational from FIFO state; push on in_valid && in_ready.
REQ-024 Push and pop same cycle: level unchanged; push into empty FIFO is not visible to a same-cycle tick (no bypass; tick reports underrun).
REQ-025 flush: level->0, push in same cycle discarded, pop suppressed, no underrun set; dac_d unchanged.
REQ-026 clr_underrun and a new underrun in the same cycle: underrun ends 1 (set wins).
REQ-027 en dropped mid-period: pending tick abandoned, FIFO contents retained.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.

Reset
REQ-029 rstn=0: state IDLE, counter 0, FIFO empty, level 0, dac_d 8'h00, upd 0, underrun 0, in_ready 1.
REQ-030 Reset mid-playback aborts immediately; no partial update of dac_d.

Configuration
REQ-031 Macro DAC_SEQ_RAMP_EN defined: in RUN with test_mode=1 each tick loads dac_d+1 (8'hFF wraps to 8'h00), upd pulses, FIFO not popped, underrun not set.
REQ-032 Macro undefined: test_mode ignored, no ramp logic synthesized.

Structure
REQ-033 Package dac_seq_pkg: state enum {IDLE, RUN}, default FIFO_DEPTH and DIV_W constants.
REQ-034 One sub-module dac_seq_fifo: synchronous FIFO with push, pop, flush, full, empty, level.

Verification
REQ-035 div=3, push 8'h10, 8'h20, en=1 -> upd at cycles 4 and 8 after en, dac_d 8'h10 then 8'h20, underrun at cycle 12.
REQ-036 Push FIFO_DEPTH samples with en=0 -> in_ready=0, level=4, extra push ignored; first tick frees one slot.
REQ-037 div=0, FIFO full, en=1 -> four consecutive upd pulses, then underrun=1; clr_underrun -> 0.
REQ-038 flush asserted with in_valid=1, level=3 -> level=0, dac_d unchanged, no underrun.
REQ-039 rstn low mid-RUN with dac_d=8'h5A -> dac_d=8'h00, level=0, in_ready=1 asynchronously.
REQ-040 DAC_SEQ_RAMP_EN defined, test_mode=1, dac_d=8'hFE, div=1 -> dac_d 8'hFF, 8'h00 on successive ticks, level unchanged.
